// File: rtl/fifo_pkg.sv
// Shared types and helpers for the flop-based FIFO family.
package fifo_pkg;

    localparam int DEPTH_DEF = 16;
    localparam int BITS_DEF  = 16;

    typedef struct packed {
        logic overflow;
        logic underflow;
    } err_flags_t;

    // Width needed to hold an occupancy of 0..depth inclusive.
    function automatic int clog2_count(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Circular index into the FIFO storage; wraps at depth-1 by compare, so depth need not be 2^n.
module fifo_ptr #(
    parameter int depth = 16,
    localparam int PW = (depth > 1) ? $clog2(depth) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          adv,
    output logic [PW-1:0] ptr
);

    localparam logic [PW-1:0] LAST = PW'(depth - 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (adv) begin
            ptr <= (ptr == LAST) ? '0 : ptr + PW'(1);
        end
    end

endmodule

// File: rtl/fifo_flops_ext.sv
// Single-clock register-array FIFO with occupancy, threshold flags, sticky errors
// and a choice of registered or first-word-fall-through read data.
module fifo_flops_ext
    import fifo_pkg::*;
#(
    parameter int depth     = DEPTH_DEF,
    parameter int bits      = BITS_DEF,
    parameter int af_thresh = depth - 2,
    parameter int ae_thresh = 2,
    parameter int fwft      = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [bits-1:0]               Din,
    input  logic                          push,
    input  logic                          pop,
    input  logic                          err_clr,
    output logic [bits-1:0]               Dout,
    output logic                          pndng,
    output logic                          full,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [clog2_count(depth)-1:0] count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int CW = clog2_count(depth);
    localparam int PW = (depth > 1) ? $clog2(depth) : 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(depth);
    localparam logic [CW-1:0] AF_C    = CW'(af_thresh);
    localparam logic [CW-1:0] AE_C    = CW'(ae_thresh);

    logic [bits-1:0] mem [depth];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;
    logic            ovf_evt;
    logic            unf_evt;
    err_flags_t      err_q;

    // Handshake: a pop is taken whenever pndng=1; a push is taken when not full,
    // or when full but a pop is taken on the same edge (the freed slot is reused).
    // Rejected requests never stall; they only raise the sticky error flags.
    assign do_pop  = pop && pndng;
    assign do_push = push && (!full || do_pop);
    assign ovf_evt = push && full && !pop;
    assign unf_evt = pop && !pndng;

    fifo_ptr #(.depth(depth)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .adv (do_push),
        .ptr (wr_ptr)
    );

    fifo_ptr #(.depth(depth)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .adv (do_pop),
        .ptr (rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= Din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (do_push && !do_pop) begin
            count <= count + CW'(1);
        end else if (do_pop && !do_push) begin
            count <= count - CW'(1);
        end
    end

    // A fresh error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= '0;
        end else begin
            err_q.overflow  <= ovf_evt | (err_q.overflow  & ~err_clr);
            err_q.underflow <= unf_evt | (err_q.underflow & ~err_clr);
        end
    end

    assign overflow     = err_q.overflow;
    assign underflow    = err_q.underflow;
    assign pndng        = (count != '0);
    assign full         = (count == DEPTH_C);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    if (fwft != 0) begin : g_fwft
        // Empty reads return zero so Dout is never driven from a stale slot.
        assign Dout = pndng ? mem[rd_ptr] : '0;
    end else begin : g_reg
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                Dout <= '0;
            end else if (do_pop) begin
                Dout <= mem[rd_ptr];
            end
        end
    end

endmodule

// File: tb/tb_fifo_flops_ext.sv
// Bench for fifo_flops_ext: a depth-16 registered instance and a depth-5 FWFT instance,
// each compared every cycle against a queue-based model.
module tb_fifo_flops_ext;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] din_in  [2];
    logic        push_in [2];
    logic        pop_in  [2];
    logic        clr_in  [2];

    logic [15:0] dout_a, dout_b;
    logic        pndng_a, pndng_b, full_a, full_b;
    logic        af_a, af_b, ae_a, ae_b, ovf_a, ovf_b, unf_a, unf_b;
    logic [4:0]  cnt_a;
    logic [2:0]  cnt_b;

    fifo_flops_ext #(.depth(16), .bits(16), .fwft(0)) dut_a (
        .clk (clk), .rst (rst), .Din (din_in[0]), .push (push_in[0]), .pop (pop_in[0]),
        .err_clr (clr_in[0]), .Dout (dout_a), .pndng (pndng_a), .full (full_a),
        .almost_full (af_a), .almost_empty (ae_a), .count (cnt_a),
        .overflow (ovf_a), .underflow (unf_a)
    );

    fifo_flops_ext #(.depth(5), .bits(16), .fwft(1)) dut_b (
        .clk (clk), .rst (rst), .Din (din_in[1]), .push (push_in[1]), .pop (pop_in[1]),
        .err_clr (clr_in[1]), .Dout (dout_b), .pndng (pndng_b), .full (full_b),
        .almost_full (af_b), .almost_empty (ae_b), .count (cnt_b),
        .overflow (ovf_b), .underflow (unf_b)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: one queue per FIFO plus the expected registered Dout and error flags.
    logic [15:0] qa[$];
    logic [15:0] qb[$];
    logic [15:0] mdout [2];
    logic        mov   [2];
    logic        mun   [2];
    int          dep   [2] = '{16, 5};
    bit          mfwft [2] = '{1'b0, 1'b1};

    function automatic int q_size(input int i);
        return (i == 0) ? qa.size() : qb.size();
    endfunction

    function automatic logic [15:0] q_head(input int i);
        return (i == 0) ? qa[0] : qb[0];
    endfunction

    task automatic model_reset();
        qa.delete();
        qb.delete();
        for (int i = 0; i < 2; i++) begin
            mdout[i] = '0;
            mov[i]   = 1'b0;
            mun[i]   = 1'b0;
        end
    endtask

    task automatic model_step(input int i);
        int          n;
        bit          pop_ok, push_ok, ovf_evt, unf_evt;
        logic [15:0] v;
        n       = q_size(i);
        pop_ok  = pop_in[i] && (n != 0);
        push_ok = push_in[i] && ((n != dep[i]) || pop_ok);
        ovf_evt = push_in[i] && (n == dep[i]) && !pop_in[i];
        unf_evt = pop_in[i] && (n == 0);
        if (pop_ok) begin
            v = (i == 0) ? qa.pop_front() : qb.pop_front();
            if (!mfwft[i]) mdout[i] = v;
        end
        if (push_ok) begin
            if (i == 0) qa.push_back(din_in[i]);
            else        qb.push_back(din_in[i]);
        end
        mov[i] = ovf_evt ? 1'b1 : (clr_in[i] ? 1'b0 : mov[i]);
        mun[i] = unf_evt ? 1'b1 : (clr_in[i] ? 1'b0 : mun[i]);
    endtask

    task automatic check_all(input int i);
        string p;
        int    n;
        n = q_size(i);
        p = (i == 0) ? "a" : "b";
        check({p, ".count"}, (i == 0) ? 32'(cnt_a) : 32'(cnt_b), 32'(n));
        check({p, ".pndng"}, (i == 0) ? 32'(pndng_a) : 32'(pndng_b), 32'(n != 0));
        check({p, ".full"},  (i == 0) ? 32'(full_a) : 32'(full_b), 32'(n == dep[i]));
        check({p, ".afull"}, (i == 0) ? 32'(af_a) : 32'(af_b), 32'(n >= dep[i] - 2));
        check({p, ".aempty"}, (i == 0) ? 32'(ae_a) : 32'(ae_b), 32'(n <= 2));
        check({p, ".ovf"},   (i == 0) ? 32'(ovf_a) : 32'(ovf_b), 32'(mov[i]));
        check({p, ".unf"},   (i == 0) ? 32'(unf_a) : 32'(unf_b), 32'(mun[i]));
        if (!mfwft[i]) begin
            check({p, ".dout"}, (i == 0) ? 32'(dout_a) : 32'(dout_b), 32'(mdout[i]));
        end else if (n != 0) begin
            check({p, ".dout"}, (i == 0) ? 32'(dout_a) : 32'(dout_b), 32'(q_head(i)));
        end
    endtask

    task automatic idle_all();
        for (int i = 0; i < 2; i++) begin
            din_in[i]  = '0;
            push_in[i] = 1'b0;
            pop_in[i]  = 1'b0;
            clr_in[i]  = 1'b0;
        end
    endtask

    task automatic drive(input int i, input logic ps, input logic pp, input logic [15:0] d,
                         input logic c);
        idle_all();
        push_in[i] = ps;
        pop_in[i]  = pp;
        din_in[i]  = d;
        clr_in[i]  = c;
    endtask

    // One clock: inputs are already set; model and DUT both step on this edge.
    task automatic cycle();
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            model_step(i);
            check_all(i);
        end
    endtask

    task automatic check_reset_state();
        for (int i = 0; i < 2; i++) check_all(i);
        check("a.dout_rst", 32'(dout_a), 32'h0);
        check("b.dout_rst", 32'(dout_b), 32'h0);
    endtask

    initial begin
        idle_all();
        model_reset();
        #1;
        check_reset_state();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Fill and drain the registered instance.
        for (int v = 0; v < 16; v++) begin drive(0, 1, 0, 16'(v), 0); cycle(); end
        for (int v = 0; v < 16; v++) begin drive(0, 0, 1, 16'h0, 0); cycle(); end
        idle_all(); cycle();

        // Overflow, drain, then clear.
        for (int v = 0; v < 40; v++) begin drive(0, 1, 0, 16'(v), 0); cycle(); end
        for (int v = 0; v < 16; v++) begin drive(0, 0, 1, 16'h0, 0); cycle(); end
        drive(0, 0, 0, 16'h0, 1); cycle();

        // Underflow; pointers must not move.
        for (int v = 0; v < 20; v++) begin drive(0, 0, 1, 16'h0, 0); cycle(); end
        drive(0, 1, 0, 16'h00A5, 0); cycle();
        drive(0, 0, 1, 16'h0, 0); cycle();
        idle_all(); cycle();
        check("a.dout_a5", 32'(dout_a), 32'h00A5);

        // Clear together with a new error: the new error wins.
        drive(0, 0, 1, 16'h0, 1); cycle();

        // Full with simultaneous push+pop, then push+pop on empty.
        for (int v = 0; v < 16; v++) begin drive(0, 1, 0, 16'($urandom_range(0, 255)), 0); cycle(); end
        for (int v = 0; v < 17; v++) begin drive(0, 1, 1, 16'h0100, 0); cycle(); end
        for (int v = 0; v < 16; v++) begin drive(0, 0, 1, 16'h0, 0); cycle(); end
        drive(0, 0, 0, 16'h0, 1); cycle();
        drive(0, 1, 1, 16'h0777, 0); cycle();
        drive(0, 0, 1, 16'h0, 1); cycle();

        // Odd depth FWFT: interleave pushes of 0..16 with random pops, then drain.
        for (int v = 0; v < 17; v++) begin
            drive(1, 1, 1'($urandom_range(0, 1)), 16'(v), 0); cycle();
            drive(1, 0, 1, 16'h0, 0); cycle();
        end
        for (int v = 0; v < 6; v++) begin drive(1, 0, 1, 16'h0, 0); cycle(); end
        drive(1, 0, 0, 16'h0, 1); cycle();

        // Random traffic on both instances with alternating fill/drain bias.
        for (int k = 0; k < 400; k++) begin
            int bias;
            bias = ((k / 40) % 2 == 0) ? 75 : 25;
            for (int i = 0; i < 2; i++) begin
                push_in[i] = ($urandom_range(0, 99) < bias);
                pop_in[i]  = ($urandom_range(0, 99) < (100 - bias));
                din_in[i]  = 16'($urandom);
                clr_in[i]  = ($urandom_range(0, 15) == 0);
            end
            cycle();
        end

        // Asynchronous reset with seven entries held and an error flag set.
        for (int v = 0; v < 20; v++) begin drive(0, 0, 1, 16'h0, 0); cycle(); end
        for (int v = 0; v < 7; v++) begin drive(0, 1, 0, 16'(v + 3), 0); cycle(); end
        idle_all();
        check("a.count7", 32'(cnt_a), 32'd7);
        @(negedge clk);
        rst = 1'b0;
        #1;
        model_reset();
        check_reset_state();
        @(posedge clk);
        #1;
        check_reset_state();
        rst = 1'b1;
        for (int v = 0; v < 4; v++) begin drive(0, 1, 0, 16'(v + 50), 0); cycle(); end
        for (int v = 0; v < 5; v++) begin drive(0, 0, 1, 16'h0, 0); cycle(); end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_flops_ext.md
Name: fifo_flops_ext

Overview:
- Parametrised successor to the flop-based FIFO: synchronous, single-clock, register-array storage.
- Adds occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags with clear, non-power-of-2 depth, and a selectable output mode: registered or first-word-fall-through.
- Drop-in buffer between producer/consumer blocks. Keeps the Din/Dout/push/pop/full/pndng handshake the team already verifies against.

Parameters:
- depth, 16, number of entries; any integer >= 2, power of 2 not required
- bits, 16, data width
- af_thresh, depth-2, almost_full asserts when count >= af_thresh; legal range 1..depth
- ae_thresh, 2, almost_empty asserts when count <= ae_thresh; legal range 0..depth-1
- fwft, 0, 0 = registered Dout (one-cycle pop latency), 1 = first-word-fall-through

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- Din  in  bits  write data, sampled when push=1
- push  in  1  write request
- pop  in  1  read request
- err_clr  in  1  synchronous clear of the sticky error flags
- Dout  out  bits  read data
- pndng  out  1  FIFO not empty (count != 0)
- full  out  1  count == depth
- almost_full  out  1  count >= af_thresh
- almost_empty  out  1  count <= ae_thresh
- count  out  CW  occupancy, where CW = $clog2(depth+1)
- overflow  out  1  sticky: a push was dropped
- underflow  out  1  sticky: a pop was made on empty

Behaviour:
- Reset (rst=0, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0, Dout=0, overflow=0, underflow=0
  - pndng=0, full=0, almost_full=0, almost_empty=1
  - Storage contents are don't-care.
- Pointers run 0..depth-1 and wrap to 0 after depth-1, with explicit compare; modulo-2^n wrap is not used.
- Accepted push (push=1 and full=0): mem[wr_ptr]<=Din; wr_ptr advances.
- Accepted pop (pop=1 and pndng=1): rd_ptr advances.
- Count:
  - +1 on push only, -1 on pop only, unchanged when both or neither are accepted.
- Push while full:
  - Without pop: data dropped, count unchanged, overflow<=1.
  - With simultaneous pop: both accepted, count stays at depth, no overflow.
- Pop while empty:
  - No pointer change, Dout holds, underflow<=1.
  - If push is also asserted, the push is accepted; count becomes 1 and underflow<=1. There is no bypass of Din to Dout in either mode.
- Error flags:
  - err_clr=1 clears overflow/underflow next edge.
  - A new error event in the same cycle as err_clr wins: the flag is set.
- fwft=0: Dout<=mem[rd_ptr] on the edge that accepts a pop; valid the cycle after; holds otherwise.
- fwft=1:
  - Dout = mem[rd_ptr] combinationally; valid whenever pndng=1.
  - pop acknowledges the current word.
  - Dout is don't-care when empty.
- Flags:
  - pndng/full/almost_* are registered, or decoded from the registered count; they never depend combinationally on push/pop.
  - full and pndng update the same edge count changes.
- No X propagation to count/flags under any push/pop combination after reset.

Decomposition:
- Package fifo_pkg:
  - function clog2_count(depth) returning CW
  - typedef for the error-flag struct {overflow, underflow}
  - localparam defaults DEPTH_DEF=16, BITS_DEF=16
- Sub-module fifo_ptr (parameter depth): pointer register with increment-and-wrap, instantiated twice (wr/rd).
- Storage, count and flag logic stay in the top module.

Test Plan:
- Fill/drain, depth=16, bits=16, fwft=0:
  - Push 0..15: full=1 at count=16, almost_full from count=14.
  - Pop 16 times: Dout sequence 0..15 each one cycle after its pop; pndng=0 after the last pop; almost_empty from count=2.
- Overflow: push 40 consecutive values 0..39 into an empty FIFO -> count saturates at 16, overflow=1 from push #17, and drain yields 0..15. Then err_clr=1 for one cycle -> overflow=0.
- Underflow: after reset, pop 20 times -> count=0, Dout stays 0, underflow=1; no pointer movement, so a subsequent push of 0xA5 then pop returns 0xA5.
- Simultaneous push/pop:
  - At count=16 with Din=0x100 for 17 cycles: count stays 16, no overflow, outputs continue in order.
  - At count=0, push+pop: count=1, underflow=1.
- Wrap and odd depth: depth=5, fwft=1. Interleave push/pop of 0..16 -> Dout equals the head value the same cycle pndng rises; order is preserved across 3+ pointer wraps.
- Reset mid-operation: assert rst=0 asynchronously between edges at count=7 -> count=0, pndng=0, Dout=0, flags clear immediately without waiting for a clock; normal operation resumes on the first edge after release.
